// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: operation codes and
// FSM state encodings, plus small decode helpers.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational result correction: applies operand signs to the unsigned
// product/quotient/remainder and substitutes the divide-by-zero result.
module mdu_sign_fix
  import mul_div_unit_pkg::*;
#(
  parameter int size = 32
) (
  input  mdu_op_e           op,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic              div_zero,
  input  logic [size-1:0]   mag_a,
  input  logic [size-1:0]   rem,
  input  logic [size-1:0]   quo,
  output logic [size-1:0]   hi,
  output logic [size-1:0]   lo
);

  logic [2*size-1:0] neg_prod;
  logic [size-1:0]   raw_a;

  always_comb begin
    neg_prod = -{rem, quo};
    raw_a    = sign_a ? -mag_a : mag_a;
    hi       = rem;
    lo       = quo;
    case (op)
      OP_MULT: begin
        if (sign_a ^ sign_b) begin
          hi = neg_prod[2*size-1:size];
          lo = neg_prod[size-1:0];
        end
      end
      OP_DIV: begin
        // Truncating division: quotient sign from the XOR, remainder follows dividend.
        lo = (sign_a ^ sign_b) ? -quo : quo;
        hi = sign_a ? -rem : rem;
      end
      default: ;
    endcase
    if (div_zero) begin
      hi = raw_a;
      lo = '1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply or
// restoring divide over magnitudes, followed by a sign-fix cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int size = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [size-1:0]   src1_i,
  input  logic [size-1:0]   src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [size-1:0]   hi_o,
  output logic [size-1:0]   lo_o,
  output logic              dz_o,
  output mdu_state_e        state_o
);

  localparam int cw = (size > 1) ? $clog2(size) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(size - 1);

  // Handshake: start_i is a single-cycle request, accepted only in IDLE or
  // DONE; while busy_o is high it is dropped. done_o pulses for one cycle
  // exactly when hi_o/lo_o/dz_o take their new values.

  mdu_state_e      state;
  mdu_op_e         op_q;
  logic            sign_a;
  logic            sign_b;
  logic [size-1:0] mag_a;
  logic [size-1:0] mag_b;
  logic [size-1:0] rem_q;
  logic [size-1:0] quo_q;
  logic [cw-1:0]   cnt;

  mdu_op_e         op_in;
  logic            in_sign_a;
  logic            in_sign_b;
  logic [size:0]   mul_sum;
  logic [size:0]   div_shift;
  logic [size:0]   div_diff;
  logic [size-1:0] rem_nxt;
  logic [size-1:0] quo_nxt;
  logic [size-1:0] fix_hi;
  logic [size-1:0] fix_lo;
  logic            div_zero;

  assign op_in     = mdu_op_e'(op_i);
  assign in_sign_a = op_is_signed(op_in) & src1_i[size-1];
  assign in_sign_b = op_is_signed(op_in) & src2_i[size-1];
  assign div_zero  = op_is_div(op_q) && (mag_b == '0);
  assign state_o   = state;

  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mag_b} : '0);
    div_shift = {rem_q, quo_q[size-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    rem_nxt   = rem_q;
    quo_nxt   = quo_q;
    if (op_is_div(op_q)) begin
      if (div_shift >= {1'b0, mag_b}) begin
        rem_nxt = div_diff[size-1:0];
        quo_nxt = {quo_q[size-2:0], 1'b1};
      end else begin
        rem_nxt = div_shift[size-1:0];
        quo_nxt = {quo_q[size-2:0], 1'b0};
      end
    end else begin
      // Product accumulates in rem_q while the multiplier shifts out of quo_q.
      rem_nxt = mul_sum[size:1];
      quo_nxt = {mul_sum[0], quo_q[size-1:1]};
    end
  end

  mdu_sign_fix #(.size(size)) u_sign_fix (
    .op       (op_q),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .div_zero (div_zero),
    .mag_a    (mag_a),
    .rem      (rem_q),
    .quo      (quo_q),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      op_q   <= OP_MULTU;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      dz_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state  <= ST_RUN;
            busy_o <= 1'b1;
            op_q   <= op_in;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            mag_a  <= in_sign_a ? -src1_i : src1_i;
            mag_b  <= in_sign_b ? -src2_i : src2_i;
            rem_q  <= '0;
            quo_q  <= in_sign_a ? -src1_i : src1_i;
            cnt    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt == last_cnt) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          hi_o   <= fix_hi;
          lo_o   <= fix_lo;
          dz_o   <= div_zero;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of operations with hand-computed
// results, plus sequences for ignored starts and mid-operation reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;
  localparam int MAX_EDGES = 200;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src1;
  logic [W-1:0]  src2;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          dz;
  mdu_state_e    state;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.size(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .op_i    (op),
    .src1_i  (src1),
    .src2_i  (src2),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo),
    .dz_o    (dz),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance, and waits
  // (bounded) for done; edges counts clock edges from the accepting edge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    edges = 1;
    #1;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    src1 = $urandom;
    src2 = $urandom;
    while (edges < MAX_EDGES) begin
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d edges, required %0d", edges, LAT);
    end
  endtask

  initial begin
    int edges;
    int done_cnt;
    int first_done;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[6] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
    vecs[9] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi_lo", {hi, lo}, 64'd0);
    check("rst_dz", {63'd0, dz}, 64'd0);
    check("rst_state", {62'd0, state}, {62'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive vectors start during DONE, exercising back-to-back acceptance.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges);
      check($sformatf("v%0d_latency", i), 64'(edges), 64'(LAT));
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      check($sformatf("v%0d_busy_in_done", i), {63'd0, busy}, 64'd0);
    end

    @(posedge clk);
    #1;
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("idle_after_done", {62'd0, state}, {62'd0, ST_IDLE});

    // Start pulse during RUN cycle 5 must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src1 = 32'd6; src2 = 32'd7;
    @(negedge clk);
    start = 1'b0; src1 = '0; src2 = '0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; first_done = 0;
    for (int e = 6; e <= 80; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = e + 1;
      end
    end
    check("ignored_start_done_count", 64'(done_cnt), 64'd1);
    check("ignored_start_latency", 64'(first_done), 64'(LAT));
    check("ignored_start_lo", {32'd0, lo}, 64'd42);
    check("ignored_start_hi", {32'd0, hi}, 64'd0);

    // Reset on RUN cycle 10 aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src1 = 32'h12345678; src2 = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_hi_lo", {hi, lo}, 64'd0);
    check("async_rst_state", {62'd0, state}, {62'd0, ST_IDLE});
    done_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) rst_n = 1'b1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_op(2'b00, 32'd2, 32'd3, edges);
    check("post_reset_latency", 64'(edges), 64'(LAT));
    check("post_reset_lo", {32'd0, lo}, 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter `size`, default 32: operand and result width.
REQ-002 SHALL have `clk_i`, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have `rst_i`, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have `start_i`, input, 1: one-cycle request to begin an operation.
REQ-005 SHALL have `op_i`, input, 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have `src1_i`, input, size: multiplicand or dividend.
REQ-007 SHALL have `src2_i`, input, size: multiplier or divisor.
REQ-008 SHALL have `busy_o`, output, 1: high while an operation is in progress.
REQ-009 SHALL have `done_o`, output, 1: one-cycle pulse when `hi_o`/`lo_o` update.
REQ-010 SHALL have `hi_o`, output, size: product high half, or remainder; feeds the writeback select stage.
REQ-011 SHALL have `lo_o`, output, size: product low half, or quotient; feeds the writeback select stage.
REQ-012 SHALL have `dz_o`, output, 1: last divide had a zero divisor; held until the next done.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL transition IDLE->RUN on `start_i`=1; `start_i`=1 while in DONE SHALL also be accepted, as from IDLE.
REQ-015 SHALL latch `op_i`, the operand magnitudes and the operand signs on acceptance; input changes after acceptance SHALL have no effect.
REQ-016 SHALL stay in RUN for exactly `size` cycles: shift-add multiply, or restoring divide, one bit per cycle, with the iteration counter counting 0..size-1.
REQ-017 SHALL spend one cycle in FIX to apply sign correction (signed ops only) and register `hi_o`/`lo_o`/`dz_o`.
REQ-018 SHALL spend one cycle in DONE with `done_o`=1, then go to IDLE unless `start_i`=1.
REQ-019 Latency: `start_i` sampled at edge N => `done_o`=1 in the cycle after edge N+size+1 (size+2 edges); this SHALL be fixed for every op, including divide-by-zero.
REQ-020 `busy_o` SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-021 `start_i` while `busy_o`=1 SHALL be ignored, with no queuing.
REQ-022 MULT SHALL give a 2*size-bit two's-complement product, negated iff the operand signs differ.
REQ-023 DIV: quotient SHALL be negative iff signs differ; remainder SHALL take the dividend's sign; truncation SHALL be toward zero.
REQ-024 DIV of the most-negative value by -1 SHALL give lo=most-negative (wraps) and hi=0.
REQ-025 Divisor 0 (DIVU or DIV) SHALL give hi=src1, lo=all ones, `dz_o`=1.
REQ-026 `hi_o`/`lo_o` SHALL hold their last value until the next FIX; they SHALL never show intermediate values.

Reset
REQ-027 `rst_i`=0 SHALL immediately force IDLE, counter=0, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, `dz_o`=0.
REQ-028 Reset mid-operation SHALL abort with no `done_o` pulse; the first `start_i` after release SHALL be accepted normally.

Structure
REQ-029 SHALL place op encodings (MULTU/MULT/DIVU/DIV) and FSM state encodings in the shared CPU definitions package.
REQ-030 SHALL keep the datapath in one module; an optional combinational helper `mdu_sign_fix` MAY hold the negate/sign-correct logic.

Verification
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, `done_o` 34 edges after start.
REQ-032 MULT 0xFFFFFFFD(-3)*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 0x64/0 -> hi=0x64, lo=0xFFFFFFFF, `dz_o`=1; a following MULTU 2*3 -> lo=6, `dz_o`=0.
REQ-035 MULTU 6*7 started; `start_i` pulsed with DIVU and changed operands on RUN cycle 5 -> exactly one `done_o`, lo=42, hi=0.
REQ-036 `rst_i`=0 on RUN cycle 10 -> `busy_o`=0 and hi/lo=0 immediately, no `done_o`; a new start after release completes in 34 edges.
